sq_deq_ctrl: RTL and testbench

SQ_DEQ_CTRL -- requirements
Module: sq_deq_ctrl

---
 rtl/sq_deq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sq_deq_ctrl.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sq_deq_ctrl.sv
// Store-queue dequeue controller.
// Tracks head/tail/count of a circular store queue, launches the head entry to the dcache as a
// single outstanding write request, and pulses issuing_onehot for the head entry when the write
// completes. A flush with a request already accepted by the dcache parks the FSM in DRAIN until
// that orphaned response returns.
//
// Ports:
//   clock, reset_n             clock and asynchronous active-low reset
//   flush                      synchronous pipeline flush (zeroes pointers and count)
//   enq_req / enq_ready        allocation handshake; enq_onehot marks the tail entry
//   ent_*                      flattened per-entry status and payload (entry i at [i*W +: W])
//   issuing_onehot             one-cycle release pulse for the head entry
//   dc_req_* / dc_resp_valid   dcache write request channel and completion
//   sq_empty, sq_full          occupancy flags
//   head_ptr                   current head index
module sq_deq_ctrl #(
    parameter int unsigned SQ_DEPTH = 8,
    parameter int unsigned PTR_W    = 3,
    parameter int unsigned DATA_W   = 64
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       enq_req,
    output logic                       enq_ready,
    output logic [SQ_DEPTH-1:0]        enq_onehot,
    input  logic [SQ_DEPTH-1:0]        ent_ready_to_deq,
    input  logic [SQ_DEPTH-1:0]        ent_complete,
    input  logic [SQ_DEPTH-1:0]        ent_mmio,
    input  logic [SQ_DEPTH*DATA_W-1:0] ent_addr,
    input  logic [SQ_DEPTH*DATA_W-1:0] ent_data,
    input  logic [SQ_DEPTH*DATA_W-1:0] ent_mask,
    input  logic [SQ_DEPTH*4-1:0]      ent_size,
    output logic [SQ_DEPTH-1:0]        issuing_onehot,
    output logic                       dc_req_valid,
    input  logic                       dc_req_ready,
    output logic [DATA_W-1:0]          dc_req_addr,
    output logic [DATA_W-1:0]          dc_req_data,
    output logic [DATA_W-1:0]          dc_req_mask,
    output logic [3:0]                 dc_req_size,
    output logic                       dc_req_mmio,
    input  logic                       dc_resp_valid,
    output logic                       sq_empty,
    output logic                       sq_full,
    output logic [PTR_W-1:0]           head_ptr
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } state_e;

    localparam logic [PTR_W:0]      FullCount = (PTR_W + 1)'(SQ_DEPTH);
    localparam logic [SQ_DEPTH-1:0] OneHot0   = {{(SQ_DEPTH - 1){1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    head_q, tail_q;
    logic [PTR_W:0]      count_q;
    logic [DATA_W-1:0]   addr_q, data_q, mask_q;
    logic [3:0]          size_q;
    logic                mmio_q;

    logic [DATA_W-1:0]   head_addr, head_data, head_mask;
    logic [3:0]          head_size;
    logic                alloc, launch, release_evt;

    // Head entry payload select.
    always_comb begin
        head_addr = '0;
        head_data = '0;
        head_mask = '0;
        head_size = '0;
        for (int unsigned i = 0; i < SQ_DEPTH; i++) begin
            if (head_q == PTR_W'(i)) begin
                head_addr = ent_addr[i*DATA_W +: DATA_W];
                head_data = ent_data[i*DATA_W +: DATA_W];
                head_mask = ent_mask[i*DATA_W +: DATA_W];
                head_size = ent_size[i*4 +: 4];
            end
        end
    end

    assign sq_empty  = (count_q == '0);
    assign sq_full   = (count_q == FullCount);
    // No allocation while an orphaned response is still outstanding after a flush.
    assign enq_ready = ~sq_full & (state_q != StDrain);
    assign enq_onehot = OneHot0 << tail_q;
    assign head_ptr   = head_q;

    assign alloc       = enq_req & enq_ready & ~flush;
    assign launch      = (state_q == StIdle) & ~sq_empty & ent_ready_to_deq[head_q] &
                         ent_complete[head_q] & ~flush;
    assign release_evt = (state_q == StWait) & dc_resp_valid & ~flush;

    assign issuing_onehot = release_evt ? (OneHot0 << head_q) : '0;

    assign dc_req_valid = (state_q == StReq);
    assign dc_req_addr  = addr_q;
    assign dc_req_data  = data_q;
    assign dc_req_mask  = mask_q;
    assign dc_req_size  = size_q;
    assign dc_req_mmio  = mmio_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (launch) state_d = StReq;
            end
            StReq: begin
                if (flush)             state_d = dc_req_ready ? StDrain : StIdle;
                else if (dc_req_ready) state_d = StWait;
            end
            StWait: begin
                // A response coinciding with flush is consumed silently.
                if (dc_resp_valid) state_d = StIdle;
                else if (flush)    state_d = StDrain;
            end
            StDrain: begin
                if (dc_resp_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (alloc)       tail_q <= tail_q + 1'b1;
                if (release_evt) head_q <= head_q + 1'b1;
                unique case ({alloc, release_evt})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
            data_q <= '0;
            mask_q <= '0;
            size_q <= '0;
            mmio_q <= 1'b0;
        end else if (launch) begin
            addr_q <= head_addr;
            data_q <= head_data;
            mask_q <= head_mask;
            size_q <= head_size;
            mmio_q <= ent_mmio[head_q];
        end
    end

endmodule

// File: tb/tb_sq_deq_ctrl.sv
// Directed scoreboard bench for sq_deq_ctrl. Stimulus pushes expected dcache requests and
// issuing pulses into queues; a negedge monitor pops and compares on every handshake/pulse.
module tb_sq_deq_ctrl;

    localparam int SQ_DEPTH = 8;
    localparam int PTR_W    = 3;
    localparam int DATA_W   = 64;

    logic                       clock = 1'b0;
    logic                       reset_n = 1'b0;
    logic                       flush = 1'b0;
    logic                       enq_req = 1'b0;
    logic                       enq_ready;
    logic [SQ_DEPTH-1:0]        enq_onehot;
    logic [SQ_DEPTH-1:0]        ent_rdy = '0;
    logic [SQ_DEPTH-1:0]        ent_cmp = '0;
    logic [SQ_DEPTH-1:0]        ent_mm = '0;
    logic [SQ_DEPTH*DATA_W-1:0] ent_addr, ent_data, ent_mask;
    logic [SQ_DEPTH*4-1:0]      ent_size;
    logic [SQ_DEPTH-1:0]        issuing_onehot;
    logic                       dc_req_valid;
    logic                       dc_req_ready = 1'b0;
    logic [DATA_W-1:0]          dc_req_addr, dc_req_data, dc_req_mask;
    logic [3:0]                 dc_req_size;
    logic                       dc_req_mmio;
    logic                       dc_resp_valid = 1'b0;
    logic                       sq_empty, sq_full;
    logic [PTR_W-1:0]           head_ptr;

    logic [DATA_W-1:0] e_addr [SQ_DEPTH];
    logic [DATA_W-1:0] e_data [SQ_DEPTH];
    logic [DATA_W-1:0] e_mask [SQ_DEPTH];
    logic [3:0]        e_size [SQ_DEPTH];

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        logic [63:0] mask;
        logic [3:0]  size;
        logic        mmio;
    } req_t;

    req_t                req_q[$];
    logic [SQ_DEPTH-1:0] iss_q[$];
    int                  n_vec = 0;
    int                  n_err = 0;

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < SQ_DEPTH; i++) begin
            ent_addr[i*DATA_W +: DATA_W] = e_addr[i];
            ent_data[i*DATA_W +: DATA_W] = e_data[i];
            ent_mask[i*DATA_W +: DATA_W] = e_mask[i];
            ent_size[i*4 +: 4]           = e_size[i];
        end
    end

    sq_deq_ctrl #(
        .SQ_DEPTH(SQ_DEPTH),
        .PTR_W   (PTR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .flush           (flush),
        .enq_req         (enq_req),
        .enq_ready       (enq_ready),
        .enq_onehot      (enq_onehot),
        .ent_ready_to_deq(ent_rdy),
        .ent_complete    (ent_cmp),
        .ent_mmio        (ent_mm),
        .ent_addr        (ent_addr),
        .ent_data        (ent_data),
        .ent_mask        (ent_mask),
        .ent_size        (ent_size),
        .issuing_onehot  (issuing_onehot),
        .dc_req_valid    (dc_req_valid),
        .dc_req_ready    (dc_req_ready),
        .dc_req_addr     (dc_req_addr),
        .dc_req_data     (dc_req_data),
        .dc_req_mask     (dc_req_mask),
        .dc_req_size     (dc_req_size),
        .dc_req_mmio     (dc_req_mmio),
        .dc_resp_valid   (dc_resp_valid),
        .sq_empty        (sq_empty),
        .sq_full         (sq_full),
        .head_ptr        (head_ptr)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clock) begin
        req_t r;
        if (reset_n) begin
            if (dc_req_valid && dc_req_ready) begin
                if (req_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected dc req: addr %0h, expected none", dc_req_addr);
                end else begin
                    r = req_q.pop_front();
                    check("req addr", dc_req_addr, r.addr);
                    check("req data", dc_req_data, r.data);
                    check("req mask", dc_req_mask, r.mask);
                    check("req size", 64'(dc_req_size), 64'(r.size));
                    check("req mmio", 64'(dc_req_mmio), 64'(r.mmio));
                end
            end
            if (issuing_onehot != '0) begin
                if (iss_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected issuing: got %0h, expected 0", issuing_onehot);
                end else begin
                    check("issuing order", 64'(issuing_onehot), 64'(iss_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n       = 1'b0;
        flush         = 1'b0;
        enq_req       = 1'b0;
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b0;
        ent_rdy       = '0;
        ent_cmp       = '0;
        ent_mm        = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic set_entry(input int i, input logic [63:0] a, input logic [63:0] d,
                             input logic [63:0] m, input logic [3:0] s, input logic mm);
        e_addr[i] = a;
        e_data[i] = d;
        e_mask[i] = m;
        e_size[i] = s;
        ent_mm[i] = mm;
    endtask

    task automatic push_req(input int i);
        req_q.push_back('{addr: e_addr[i], data: e_data[i], mask: e_mask[i],
                          size: e_size[i], mmio: ent_mm[i]});
    endtask

    task automatic enqueue(input int n);
        for (int k = 0; k < n; k++) begin
            enq_req = 1'b1;
            tick();
        end
        enq_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " dc_req_valid"}, 64'(dc_req_valid), 64'd0);
        check({tag, " issuing"}, 64'(issuing_onehot), 64'd0);
        check({tag, " sq_empty"}, 64'(sq_empty), 64'd1);
        check({tag, " sq_full"}, 64'(sq_full), 64'd0);
        check({tag, " enq_ready"}, 64'(enq_ready), 64'd1);
        check({tag, " enq_onehot"}, 64'(enq_onehot), 64'h01);
        check({tag, " head_ptr"}, 64'(head_ptr), 64'd0);
        check({tag, " payload addr"}, dc_req_addr, 64'd0);
    endtask

    initial begin
        int  nrel;
        int  last_rise;
        logic hs, prev_valid;

        for (int i = 0; i < SQ_DEPTH; i++) set_entry(i, '0, '0, '0, '0, 1'b0);

        // Reset state.
        do_reset();
        #1;
        check_reset_outputs("reset");

        // Single MMIO store.
        set_entry(0, 64'h1000, 64'hDEAD_BEEF_0000_0001, 64'h0000_0000_0000_00FF, 4'd3, 1'b1);
        enq_req = 1'b1;
        #1;
        check("s1 enq_onehot", 64'(enq_onehot), 64'h01);
        tick();
        enq_req = 1'b0;
        #1;
        check("s1 not empty", 64'(sq_empty), 64'd0);
        ent_rdy[0] = 1'b1;
        ent_cmp[0] = 1'b1;
        push_req(0);
        tick();
        #1;
        check("s1 valid +1", 64'(dc_req_valid), 64'd1);
        check("s1 addr", dc_req_addr, 64'h1000);
        check("s1 mmio", 64'(dc_req_mmio), 64'd1);
        tick();
        check("s1 valid +2", 64'(dc_req_valid), 64'd1);
        tick();
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        #1;
        check("s1 wait valid", 64'(dc_req_valid), 64'd0);
        check("s1 no early issue", 64'(issuing_onehot), 64'd0);
        tick();
        dc_resp_valid = 1'b1;
        iss_q.push_back(8'h01);
        #1;
        check("s1 issuing", 64'(issuing_onehot), 64'h01);
        tick();
        dc_resp_valid = 1'b0;
        ent_rdy = '0;
        ent_cmp = '0;
        #1;
        check("s1 head_ptr", 64'(head_ptr), 64'd1);
        check("s1 sq_empty", 64'(sq_empty), 64'd1);
        check("s1 issuing off", 64'(issuing_onehot), 64'd0);

        // Fill and wrap.
        do_reset();
        for (int i = 0; i < SQ_DEPTH; i++) begin
            set_entry(i, 64'h2000 + 64'(i) * 64'h40, {32'hCAFE_0000 + 32'(i), 32'h1234_5600 + 32'(i)},
                      64'h00FF_00FF_0000_0000 | 64'(i), 4'(i + 1), 1'(i % 2));
        end
        for (int i = 0; i < SQ_DEPTH; i++) begin
            enq_req = 1'b1;
            #1;
            check("fill enq_onehot", 64'(enq_onehot), 64'(1) << i);
            tick();
        end
        #1;
        check("fill sq_full", 64'(sq_full), 64'd1);
        check("fill enq_ready", 64'(enq_ready), 64'd0);
        check("fill tail wrapped", 64'(enq_onehot), 64'h01);
        tick();
        enq_req = 1'b0;
        #1;
        check("9th ignored full", 64'(sq_full), 64'd1);
        for (int i = 0; i < SQ_DEPTH; i++) begin
            push_req(i);
            iss_q.push_back(8'(1 << i));
        end
        ent_rdy      = '1;
        ent_cmp      = '1;
        dc_req_ready = 1'b1;
        hs = 1'b0;
        prev_valid = 1'b0;
        nrel = 0;
        last_rise = -1;
        for (int c = 0; c < 60 && nrel < SQ_DEPTH; c++) begin
            dc_resp_valid = hs;
            #1;
            if (dc_req_valid && !prev_valid) begin
                if (last_rise >= 0) check("req spacing", 64'(c - last_rise), 64'd3);
                last_rise = c;
            end
            prev_valid = dc_req_valid;
            hs = dc_req_valid & dc_req_ready;
            if (issuing_onehot != '0) nrel++;
            tick();
        end
        dc_resp_valid = 1'b0;
        dc_req_ready  = 1'b0;
        ent_rdy       = '0;
        ent_cmp       = '0;
        check("drain release count", 64'(nrel), 64'(SQ_DEPTH));
        #1;
        check("wrap head_ptr", 64'(head_ptr), 64'd0);
        check("wrap sq_empty", 64'(sq_empty), 64'd1);
        enq_req = 1'b1;
        #1;
        check("wrap enq_onehot", 64'(enq_onehot), 64'h01);
        tick();
        enq_req = 1'b0;

        // Simultaneous enqueue and release at count 3.
        do_reset();
        set_entry(0, 64'h3000, 64'h3333, 64'h0F, 4'd2, 1'b0);
        enqueue(3);
        ent_rdy[0]   = 1'b1;
        ent_cmp[0]   = 1'b1;
        dc_req_ready = 1'b1;
        push_req(0);
        tick();
        #1;
        check("s3 valid", 64'(dc_req_valid), 64'd1);
        tick();
        dc_req_ready  = 1'b0;
        enq_req       = 1'b1;
        dc_resp_valid = 1'b1;
        iss_q.push_back(8'h01);
        #1;
        check("s3 tail before", 64'(enq_onehot), 64'h08);
        check("s3 issuing", 64'(issuing_onehot), 64'h01);
        tick();
        enq_req       = 1'b0;
        dc_resp_valid = 1'b0;
        ent_rdy       = '0;
        ent_cmp       = '0;
        #1;
        check("s3 head_ptr", 64'(head_ptr), 64'd1);
        check("s3 tail after", 64'(enq_onehot), 64'h10);
        enqueue(4);
        #1;
        check("s3 count 7 not full", 64'(sq_full), 64'd0);
        enqueue(1);
        #1;
        check("s3 count 8 full", 64'(sq_full), 64'd1);

        // Backpressure.
        do_reset();
        set_entry(0, 64'hABCD0, 64'h5A5A_A5A5_0F0F_F0F0, 64'hFF00, 4'd1, 1'b0);
        enqueue(1);
        ent_rdy[0] = 1'b1;
        ent_cmp[0] = 1'b1;
        push_req(0);
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp valid", 64'(dc_req_valid), 64'd1);
            check("bp addr", dc_req_addr, 64'hABCD0);
            check("bp data", dc_req_data, 64'h5A5A_A5A5_0F0F_F0F0);
            check("bp no issue", 64'(issuing_onehot), 64'd0);
            tick();
        end
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready  = 1'b0;
        dc_resp_valid = 1'b1;
        iss_q.push_back(8'h01);
        tick();
        dc_resp_valid = 1'b0;
        ent_rdy       = '0;
        ent_cmp       = '0;
        #1;
        check("bp head_ptr", 64'(head_ptr), 64'd1);

        // Flush in WAIT.
        do_reset();
        set_entry(0, 64'h4000, 64'h4444, 64'hF0, 4'd3, 1'b0);
        enqueue(2);
        ent_rdy[0] = 1'b1;
        ent_cmp[0] = 1'b1;
        push_req(0);
        tick();
        dc_req_ready = 1'b1;
        tick();
        dc_req_ready = 1'b0;
        flush        = 1'b1;
        enq_req      = 1'b1;
        tick();
        flush   = 1'b0;
        enq_req = 1'b0;
        ent_rdy = '0;
        ent_cmp = '0;
        #1;
        check("fl head_ptr", 64'(head_ptr), 64'd0);
        check("fl tail", 64'(enq_onehot), 64'h01);
        check("fl sq_empty", 64'(sq_empty), 64'd1);
        for (int k = 0; k < 3; k++) begin
            check("drain enq_ready", 64'(enq_ready), 64'd0);
            check("drain valid", 64'(dc_req_valid), 64'd0);
            tick();
        end
        dc_resp_valid = 1'b1;
        #1;
        check("drain no issue", 64'(issuing_onehot), 64'd0);
        tick();
        dc_resp_valid = 1'b0;
        #1;
        check("drain exit enq_ready", 64'(enq_ready), 64'd1);

        // Flush in REQ without handshake drops the request.
        do_reset();
        enqueue(1);
        ent_rdy[0] = 1'b1;
        ent_cmp[0] = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush   = 1'b0;
        ent_rdy = '0;
        ent_cmp = '0;
        #1;
        check("flreq valid", 64'(dc_req_valid), 64'd0);
        check("flreq idle enq_ready", 64'(enq_ready), 64'd1);

        // Async reset pulse while in REQ.
        do_reset();
        enqueue(2);
        ent_rdy[0] = 1'b1;
        ent_cmp[0] = 1'b1;
        tick();
        #1;
        check("ar valid before", 64'(dc_req_valid), 64'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async");
        tick();
        ent_rdy = '0;
        ent_cmp = '0;
        tick();
        reset_n       = 1'b1;
        dc_resp_valid = 1'b1;
        #1;
        check("ar resp ignored", 64'(issuing_onehot), 64'd0);
        tick();
        dc_resp_valid = 1'b0;
        #1;
        check("ar no drain", 64'(enq_ready), 64'd1);

        tick();
        check("req queue drained", 64'(req_q.size()), 64'd0);
        check("issue queue drained", 64'(iss_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
